// File: rtl/sync_link_pkg.sv
// sync_link_pkg: shared state encoding and sync-word constants for the sync-word serial link.
package sync_link_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_DATA = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    localparam int SYNC_W = 6;
    localparam logic [SYNC_W-1:0] SYNC_WORD = 6'b101101;

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = 1;
        if (a > m) m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction
endpackage

// File: rtl/piso_shift_reg.sv
// piso_shift_reg: parallel-load, MSB-first serial-out shift register.
module piso_shift_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] d,
    output logic         q
);
    logic [W-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     sr <= '0;
        else if (load)  sr <= d;
        else if (shift) sr <= sr << 1;
    end

    assign q = sr[W-1];
endmodule

// File: rtl/sync_frame_tx.sv
// sync_frame_tx: serialises each accepted payload as sync word, payload (MSB first), then idle gap zeros.
module sync_frame_tx
    import sync_link_pkg::*;
#(
    parameter int                DATA_W = 8,
    parameter int                SYNC_W = sync_link_pkg::SYNC_W,
    parameter logic [SYNC_W-1:0] SYNC   = SYNC_WORD,
    parameter int                GAP    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              x,
    output logic              tx_busy,
    output logic              frame_done
);
    localparam int CW = cnt_width(SYNC_W, DATA_W, GAP);

    state_t            state, nstate;
    logic [CW-1:0]     cnt, ncnt;
    logic [SYNC_W-1:0] sync_sh;
    logic              accept, shift, sd, x_n, fd_n;

    assign accept = load_valid & load_ready;

    piso_shift_reg #(.W(DATA_W)) u_piso (
        .clk  (clk),
        .rst_n(rst_n),
        .load (accept),
        .shift(shift),
        .d    (load_data),
        .q    (sd)
    );

    // state/cnt describe the bit currently on x, so x is registered from the next-state bit
    always_comb begin
        nstate = state;
        ncnt   = cnt;
        fd_n   = 1'b0;
        case (state)
            ST_IDLE: if (accept) begin
                nstate = ST_SYNC;
                ncnt   = CW'(SYNC_W - 1);
            end
            ST_SYNC: if (cnt == '0) begin
                nstate = ST_DATA;
                ncnt   = CW'(DATA_W - 1);
            end else ncnt = cnt - 1'b1;
            ST_DATA: if (cnt == '0) begin
                fd_n   = 1'b1;
                nstate = (GAP > 0) ? ST_GAP : ST_IDLE;
                ncnt   = (GAP > 0) ? CW'(GAP - 1) : '0;
            end else ncnt = cnt - 1'b1;
            ST_GAP: if (cnt == '0) nstate = ST_IDLE;
            else ncnt = cnt - 1'b1;
        endcase
        shift   = nstate == ST_DATA;
        sync_sh = SYNC >> ncnt;
        x_n     = (nstate == ST_SYNC) ? sync_sh[0] : (nstate == ST_DATA) ? sd : 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            x          <= 1'b0;
            load_ready <= 1'b0;
            tx_busy    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= nstate;
            cnt        <= ncnt;
            x          <= x_n;
            load_ready <= nstate == ST_IDLE;
            tx_busy    <= nstate != ST_IDLE;
            frame_done <= fd_n;
        end
    end
endmodule

// File: tb/tb_sync_frame_tx.sv
// tb_sync_frame_tx: randomized and directed checks of sync_frame_tx against a frame-position reference model.
module tb_sync_frame_tx;
    localparam int SW = 6;
    localparam int DW = 8;
    localparam int GP = 2;
    localparam int FL = SW + DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_valid = 1'b0;
    logic [DW-1:0] load_data = '0;
    logic          load_ready, x, tx_busy, frame_done;

    int      checks = 0;
    int      errors = 0;
    int      pos = 0;
    bit      rdy_m = 1'b0;
    bit [DW-1:0] cap = '0;
    bit [5:0] hist = '0;
    int      zc = 0;

    sync_frame_tx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_valid(load_valid),
        .load_data (load_data),
        .load_ready(load_ready),
        .x         (x),
        .tx_busy   (tx_busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h pos=%0d t=%0t", tag, obs, expv, pos, $time);
        end
    endtask

    function automatic logic exp_x(input int p, input bit [DW-1:0] d);
        bit [FL-1:0] bits;
        bits = {6'b101101, d};
        return (p >= 1 && p <= FL) ? bits[FL-p] : 1'b0;
    endfunction

    task automatic step(input logic v, input logic [DW-1:0] d);
        load_valid = v;
        load_data  = d;
        @(posedge clk);
        if (rdy_m && v) begin
            pos = 1;
            cap = d;
        end else if (pos > 0) begin
            pos = (pos >= FL + GP) ? 0 : pos + 1;
        end
        rdy_m = (pos == 0);
        @(negedge clk);
        chk("x", 32'(x), 32'(exp_x(pos, cap)));
        chk("tx_busy", 32'(tx_busy), 32'(pos != 0));
        chk("load_ready", 32'(load_ready), 32'(rdy_m));
        chk("frame_done", 32'(frame_done), 32'(pos == FL + 1));
        hist = {hist[4:0], x};
        if (hist == 6'b101101) zc++;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_x", 32'(x), 32'd0);
        chk("rst_ready", 32'(load_ready), 32'd0);
        chk("rst_busy", 32'(tx_busy), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        rst_n = 1'b1;
        repeat (4) step(1'b0, '0);

        step(1'b1, 8'hA5);
        repeat (FL + GP) step(1'b0, '0);

        zc = 0;
        hist = '0;
        repeat (2 * (FL + GP + 1)) step(1'b1, 8'h00);
        repeat (3) step(1'b0, '0);
        chk("z_count_00x2", 32'(zc), 32'd2);

        zc = 0;
        hist = '0;
        step(1'b1, 8'h2D);
        repeat (FL + GP + 2) step(1'b0, '0);
        chk("z_count_2d", 32'(zc), 32'd2);

        repeat (40) step(1'b1, DW'($urandom));
        repeat (80) step(1'($urandom_range(0, 1)), DW'($urandom));
        repeat (FL + GP + 1) step(1'b0, '0);

        step(1'b1, DW'($urandom));
        while (pos != SW + 3) step(1'b0, '0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_x", 32'(x), 32'd0);
        chk("arst_busy", 32'(tx_busy), 32'd0);
        chk("arst_ready", 32'(load_ready), 32'd0);
        chk("arst_done", 32'(frame_done), 32'd0);
        pos = 0;
        rdy_m = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) step(1'b0, '0);
        step(1'b1, 8'h3C);
        repeat (FL + GP + 1) step(1'b0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sync_frame_tx.md
Name: sync_frame_tx

Overview:
- Bit-serial frame transmitter: the transmit end of the sync-word serial link.
- Accepts a parallel payload through a valid/ready handshake and drives a single serial line `x`.
- Each frame is the sync word 101101 (MSB first), then DATA_W payload bits (MSB first), then GAP idle zeros.
- `x` feeds the team's Moore sequence detector; detector `z` marks the end of each sync word.

Parameters:
- DATA_W, 8: payload bits per frame (≥1).
- SYNC_W, 6: sync word width.
- SYNC, 6'b101101: sync word, sent MSB first.
- GAP, 2: forced zero bits after payload (≥0).

Ports:
- Clock  in  1  single system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- load_valid  in  1  payload offered.
- load_data  in  DATA_W  payload, captured on accept.
- load_ready  out  1  block can accept a payload.
- x  out  1  registered serial line; idle level 0.
- tx_busy  out  1  frame in progress (SYNC, DATA or GAP state).
- frame_done  out  1  one-cycle pulse after the last payload bit.

Behaviour:
- Reset (Reset=0, async) forces: state IDLE, x=0, load_ready=0, tx_busy=0, frame_done=0, shift register and counter cleared.
  - Applies mid-frame too: the frame is abandoned with no partial completion and no frame_done.
- First rising edge after reset release sets load_ready=1.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, SYNC, DATA, GAP. Bit counter width is clog2(max(SYNC_W, DATA_W, GAP, 1)) + 1.
- IDLE:
  - x=0, load_ready=1.
  - Accept at the edge where load_valid & load_ready: capture load_data, load_ready→0, tx_busy→1, counter=SYNC_W-1, go to SYNC.
  - load_data is ignored after the accept edge.
- SYNC:
  - x=SYNC[cnt] for SYNC_W cycles; cnt decrements.
  - At cnt=0: counter=DATA_W-1, go to DATA.
- DATA:
  - x=payload[cnt] for DATA_W cycles.
  - At cnt=0: frame_done=1 for the next cycle only.
  - If GAP>0, go to GAP with counter=GAP-1; else go to IDLE.
- GAP:
  - x=0 for GAP cycles; load_ready stays 0.
  - At cnt=0, go to IDLE.
- Entering IDLE: load_ready=1 and tx_busy=0 in the same cycle.
- Latency: the first sync bit appears on x in the cycle after the accept edge.
- Frame length is SYNC_W+DATA_W cycles. Accept-to-accept minimum is SYNC_W+DATA_W+GAP+1 cycles, so at least GAP+1 zeros separate frames.
- load_valid while load_ready=0 has no effect; the source holds load_valid until accepted.
- Payload containing the sync pattern is not escaped. A detector may fire inside the payload; this is documented link behaviour.

Decomposition:
- Shared package sync_link_pkg holds:
  - state enum: IDLE=2'd0, SYNC=2'd1, DATA=2'd2, GAP=2'd3;
  - SYNC_WORD=6'b101101 and SYNC_W=6, shared with the detector side.
- One natural sub-module: piso_shift_reg.
  - Parallel load, MSB-first shift enable, serial out.
  - Used for the payload; the sync word is indexed from the constant.
- FSM and counter stay in sync_frame_tx.

Test Plan:
- Reset release, load_valid=0 → x=0, tx_busy=0 throughout; load_ready=1 from the first edge after release.
- Accept 8'hA5 at edge E0 (GAP=2):
  - x over cycles 1–14 = 1,0,1,1,0,1, 1,0,1,0,0,1,0,1;
  - x=0 in cycles 15–16; frame_done=1 in cycle 15 only;
  - load_ready=1 from cycle 17.
- Loopback into the sequence detector with payload 8'h00 → z=1 exactly once per frame, in the cycle after the 6th sync bit is sampled; two back-to-back frames give two z pulses.
- Payload 8'h2D (00101101) in loopback → two z pulses per frame (sync plus embedded match); confirms documented no-escaping behaviour.
- load_valid held high with changing load_data during a frame → no second accept until IDLE; transmitted payload equals data captured at the accept edge.
- Reset=0 asserted during DATA bit 3 → x=0 and tx_busy=0 immediately (asynchronous); no frame_done; the next frame after release starts cleanly with 101101.
